// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch (m0, read-only)
// and load/store (m1). One transaction in flight; round-robin on contention.
module mem_bus_arbiter #(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

    state_t        state, state_next;
    logic          last_grant;
    logic          owner;
    logic [3:0]    lat_cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;

    always_comb begin
        state_next = state;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = m0_rdata_q;
        m1_rdata   = m1_rdata_q;
        mem_addr   = addr_q;
        mem_din    = '0;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie, the master that did not win last time is served.
                if (m0_req && (!m1_req || last_grant)) begin
                    m0_gnt     = 1'b1;
                    mem_addr   = m0_addr;
                    state_next = RD_WAIT;
                end else if (m1_req) begin
                    m1_gnt   = 1'b1;
                    mem_addr = m1_addr;
                    if (m1_we) begin
                        mem_we  = 1'b1;
                        mem_din = m1_wdata;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt == '0) begin
                    state_next = IDLE;
                    if (owner) begin
                        m1_rvalid = 1'b1;
                        m1_rdata  = mem_dout;
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_rdata  = mem_dout;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_cnt    <= '0;
            addr_q     <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state <= state_next;
            if (m0_gnt) begin
                last_grant <= 1'b0;
                owner      <= 1'b0;
                addr_q     <= m0_addr;
                lat_cnt    <= LAT_INIT;
            end else if (m1_gnt) begin
                last_grant <= 1'b1;
                owner      <= 1'b1;
                addr_q     <= m1_addr;
                lat_cnt    <= LAT_INIT;
            end else if (state == RD_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (m0_rvalid) m0_rdata_q <= mem_dout;
            if (m1_rvalid) m1_rdata_q <= mem_dout;
        end
    end

    assign busy = (state == RD_WAIT);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0;
    logic        m1_we = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_we, busy;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    bit          armed = 1'b0;

    mem_bus_arbiter #(.READ_LAT(LAT), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Memory device: READ_LAT-deep read pipeline, write on the clock edge.
    logic [31:0] dev_mem [0:255];
    logic        written [0:255];
    logic [31:0] pipe [0:LAT-1];
    logic [31:0] rd_word;
    assign rd_word  = written[mem_addr[7:0]] ? dev_mem[mem_addr[7:0]] : init_word(mem_addr[7:0]);
    assign mem_dout = pipe[LAT-1];

    always @(posedge clk) begin
        if (mem_we) begin
            dev_mem[mem_addr[7:0]] <= mem_din;
            written[mem_addr[7:0]] <= 1'b1;
        end
        pipe[0] <= rd_word;
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end

    initial begin
        for (int i = 0; i < 256; i++) written[i] = 1'b0;
        for (int i = 0; i < int'(LAT); i++) pipe[i] = '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level reference: a pending read completes at an absolute cycle.
    logic [31:0] ref_mem [0:255];
    initial begin : model
        bit          pend;
        int          own, last, g;
        int unsigned due;
        logic [31:0] rval, aq, rq0, rq1;
        logic        e_g0, e_g1, e_rv0, e_rv1, e_we, e_busy;
        logic [31:0] e_rd0, e_rd1, e_addr, e_din;
        pend = 1'b0; own = 0; last = 1; due = 0; rval = '0; aq = '0; rq0 = '0; rq1 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        forever begin
            @(negedge clk);
            if (armed) begin
                e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0; e_busy = 0;
                e_rd0 = rq0; e_rd1 = rq1; e_addr = aq; e_din = '0; g = -1;
                if (pend) begin
                    e_busy = 1;
                    if (cyc == due) begin
                        if (own == 1) begin e_rv1 = 1; e_rd1 = rval; end
                        else begin e_rv0 = 1; e_rd0 = rval; end
                    end
                end else begin
                    if (m0_req && m1_req) g = (last == 1) ? 0 : 1;
                    else if (m0_req) g = 0;
                    else if (m1_req) g = 1;
                    if (g == 0) begin e_g0 = 1; e_addr = m0_addr; end
                    if (g == 1) begin
                        e_g1 = 1; e_addr = m1_addr;
                        if (m1_we) begin e_we = 1; e_din = m1_wdata; end
                    end
                end
                chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
                chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
                chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
                chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
                chk("m0_rdata", m0_rdata, e_rd0);
                chk("m1_rdata", m1_rdata, e_rd1);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_din", mem_din, e_din);
                chk("busy", 32'(busy), 32'(e_busy));
                if (reset) begin
                    pend = 0; last = 1; aq = '0; rq0 = '0; rq1 = '0;
                end else begin
                    if (pend && cyc == due) begin
                        pend = 0;
                        if (own == 1) rq1 = rval; else rq0 = rval;
                    end
                    if (g >= 0) begin
                        last = g;
                        aq = e_addr;
                        if (g == 1 && m1_we) ref_mem[e_addr[7:0]] = m1_wdata;
                        else begin
                            pend = 1; own = g; due = cyc + LAT; rval = ref_mem[e_addr[7:0]];
                        end
                    end
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic g0, g1, rst;
        g0 = 0; g1 = 0;
        tick();
        armed = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rdata0", m0_rdata, 32'h0);
        chk("rst_rdata1", m1_rdata, 32'h0);

        // m0 read of 0x10 held high: second grant right after the first read completes.
        tick(); reset = 0; m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        chk("a_gnt", 32'(m0_gnt), 32'd1);
        chk("a_addr", mem_addr, 32'h10);
        for (int i = 1; i <= int'(LAT); i++) begin
            tick(); @(negedge clk);
            chk("a_busy", 32'(busy), 32'd1);
            chk("a_nognt", 32'(m0_gnt), 32'd0);
            chk("a_rvalid", 32'(m0_rvalid), (i == int'(LAT)) ? 32'd1 : 32'd0);
            if (i == int'(LAT)) chk("a_rdata", m0_rdata, 32'hDEADBEEF);
        end
        tick(); @(negedge clk);
        chk("a_regnt", 32'(m0_gnt), 32'd1);
        tick(); m0_req = 0;
        repeat (LAT) tick();

        // m1 write then read-back; m1 drops req after the read grant while m0 starts asking.
        tick(); m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        @(negedge clk);
        chk("b_wgnt", 32'(m1_gnt), 32'd1);
        chk("b_we", 32'(mem_we), 32'd1);
        chk("b_din", mem_din, 32'h12345678);
        tick(); m1_we = 0;
        @(negedge clk);
        chk("b_rgnt", 32'(m1_gnt), 32'd1);
        chk("b_rwe", 32'(mem_we), 32'd0);
        tick(); m1_req = 0; m0_req = 1; m0_addr = 32'h10;
        for (int i = 1; i <= int'(LAT); i++) begin
            if (i > 1) tick();
            @(negedge clk);
            chk("b_busy", 32'(busy), 32'd1);
            chk("b_m0wait", 32'(m0_gnt), 32'd0);
            chk("b_m0rv", 32'(m0_rvalid), 32'd0);
        end
        chk("b_rvalid", 32'(m1_rvalid), 32'd1);
        chk("b_rdata", m1_rdata, 32'h12345678);
        tick(); @(negedge clk);
        chk("b_m0gnt", 32'(m0_gnt), 32'd1);
        chk("b_no_m1", 32'(m1_gnt), 32'd0);
        chk("b_hold", m1_rdata, 32'h12345678);
        tick(); m0_req = 0;
        repeat (LAT) tick();

        // Reset in the middle of a read aborts it.
        tick(); m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        @(negedge clk);
        chk("d_gnt", 32'(m1_gnt), 32'd1);
        tick(); m1_req = 0; reset = 1;
        tick(); reset = 0;
        for (int i = 0; i < int'(LAT) + 1; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("d_busy", 32'(busy), 32'd0);
            chk("d_rvalid", 32'(m1_rvalid), 32'd0);
            chk("d_rdata", m1_rdata, 32'h0);
        end

        // Both requesting continuously right after reset: m0 first, then alternate.
        tick(); m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        for (int k = 0; k < 4 * int'(LAT + 1); k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk("c_g0", 32'(m0_gnt),
                (k % int'(LAT + 1) == 0 && (k / int'(LAT + 1)) % 2 == 0) ? 32'd1 : 32'd0);
            chk("c_g1", 32'(m1_gnt),
                (k % int'(LAT + 1) == 0 && (k / int'(LAT + 1)) % 2 == 1) ? 32'd1 : 32'd0);
        end
        tick(); m0_req = 0; m1_req = 0;
        repeat (LAT + 1) tick();

        // Randomized traffic with occasional resets; requests stay up until granted.
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            reset = rst;
            if (rst) begin
                m0_req = 0;
                m1_req = 0;
            end else begin
                if (!m0_req || g0) begin
                    m0_req  = ($urandom_range(0, 9) < 6);
                    m0_addr = 32'($urandom_range(0, 255));
                end
                if (!m1_req || g1) begin
                    m1_req   = ($urandom_range(0, 9) < 6);
                    m1_we    = $urandom_range(0, 1) == 1;
                    m1_addr  = 32'($urandom_range(0, 255));
                    m1_wdata = $urandom;
                end
            end
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
        end
        tick(); reset = 0; m0_req = 0; m1_req = 0;
        repeat (LAT + 2) tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
